// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash command sequencer: request encodings,
// 25-series flash opcodes, sequencer state encoding and payload helpers.
package spi_flash_pkg;

  // Request encodings on op_code
  localparam logic [1:0] OPC_READ_ID = 2'd0;
  localparam logic [1:0] OPC_READ    = 2'd1;
  localparam logic [1:0] OPC_PROGRAM = 2'd2;
  localparam logic [1:0] OPC_ERASE   = 2'd3;

  // Flash command bytes
  localparam logic [7:0] CMD_WREN = 8'h06;
  localparam logic [7:0] CMD_RDSR = 8'h05;
  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_PP   = 8'h02;
  localparam logic [7:0] CMD_CE   = 8'hC7;
  localparam logic [7:0] CMD_RDID = 8'h9F;

  // Sequencer states
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WREN     = 3'd1;
  localparam logic [2:0] ST_XFER     = 3'd2;
  localparam logic [2:0] ST_POLL_GAP = 3'd3;
  localparam logic [2:0] ST_POLL     = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

  localparam int unsigned WIP_BIT   = 0;
  localparam logic [3:0]  MAX_BYTES = 4'd12;

  function automatic logic nb_valid(input logic [3:0] nb);
    return (nb != 4'd0) && (nb <= MAX_BYTES);
  endfunction

  function automatic logic [3:0] nb_clamp(input logic [3:0] nb);
    return nb_valid(nb) ? nb : MAX_BYTES;
  endfunction

  // Command + address + nb data bytes, in bits
  function automatic logic [7:0] xfer_bits(input logic [3:0] nb);
    return 8'd32 + 8'({nb, 3'b000});
  endfunction

  // {cmd, addr} followed by nb byte slots, right-aligned
  function automatic logic [127:0] cmd_addr(input logic [7:0] cmd, input logic [23:0] a,
                                            input logic [3:0] nb);
    return 128'({cmd, a}) << {nb, 3'b000};
  endfunction

endpackage

// File: rtl/spi_xfer_hs.sv
// One spictl transfer handshake: registered trig pulse, ACK phase bounded by
// ACK_MAX cycles waiting for isbusy to rise, then WAIT phase for its fall.
// Ports: clk/rst_n; start_c requests a transfer; isbusy from spictl;
// trig to spictl; done_c pulses in the cycle isbusy is seen low after ACK;
// timeout_c pulses when the ACK window expires.
module spi_xfer_hs #(
  parameter int unsigned ACK_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_c,
  input  logic isbusy,
  output logic trig,
  output logic done_c,
  output logic timeout_c
);

  localparam int unsigned CW = (ACK_MAX < 1) ? 1 : $clog2(ACK_MAX + 1);

  localparam logic [1:0] PH_IDLE = 2'd0;
  localparam logic [1:0] PH_ACK  = 2'd1;
  localparam logic [1:0] PH_WAIT = 2'd2;

  logic [1:0]    ph, ph_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          trig_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph   <= PH_IDLE;
      cnt  <= '0;
      trig <= 1'b0;
    end else begin
      ph   <= ph_d;
      cnt  <= cnt_d;
      trig <= trig_d;
    end
  end

  // Phase sequencing; an isbusy already high on ACK entry counts as the ack
  always_comb begin
    ph_d      = ph;
    cnt_d     = cnt;
    trig_d    = 1'b0;
    done_c    = 1'b0;
    timeout_c = 1'b0;
    case (ph)
      PH_ACK: begin
        if (isbusy) begin
          ph_d = PH_WAIT;
        end else if (32'(cnt) >= ACK_MAX) begin
          timeout_c = 1'b1;
          ph_d      = PH_IDLE;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      PH_WAIT: begin
        if (!isbusy) begin
          done_c = 1'b1;
          ph_d   = PH_IDLE;
        end
      end
      default: ph_d = PH_IDLE;
    endcase
    if (start_c) begin
      trig_d = 1'b1;
      ph_d   = PH_ACK;
      cnt_d  = '0;
    end
  end

endmodule

// File: rtl/spi_flash_seq.sv
// Flash command sequencer upstream of spictl: turns READ_ID / READ / PROGRAM /
// ERASE_CHIP requests into WREN, command and RDSR-poll transfer sequences.
// Ports: sclk/srst_n; request side op_start, op_code, addr, nbytes, wdata,
// busy, op_done, op_err, rdata; spictl side trig, datalength, senddata,
// isbusy, recvdata.
module spi_flash_seq
  import spi_flash_pkg::*;
#(
  parameter int unsigned POLL_GAP = 1000,
  parameter int unsigned POLL_MAX = 65535,
  parameter int unsigned ACK_MAX  = 15
) (
  input  logic         sclk,
  input  logic         srst_n,
  input  logic         op_start,
  input  logic [1:0]   op_code,
  input  logic [23:0]  addr,
  input  logic [3:0]   nbytes,
  input  logic [95:0]  wdata,
  output logic         busy,
  output logic         op_done,
  output logic         op_err,
  output logic [95:0]  rdata,
  output logic         trig,
  output logic [7:0]   datalength,
  output logic [127:0] senddata,
  input  logic         isbusy,
  input  logic [127:0] recvdata
);

  localparam int unsigned GW = (POLL_GAP < 1) ? 1 : $clog2(POLL_GAP + 1);
  localparam int unsigned PW = (POLL_MAX < 1) ? 1 : $clog2(POLL_MAX + 1);

  logic [2:0]    st, st_d;
  logic          busy_d, op_done_d, op_err_d;
  logic [95:0]   rdata_d;
  logic [7:0]    dl_d;
  logic [127:0]  sd_d;
  logic [1:0]    op_q, op_d;
  logic [23:0]   addr_q, addr_d;
  logic [3:0]    nb_q, nb_d;
  logic [95:0]   wdata_q, wd_d;
  logic [GW-1:0] gap_cnt, gap_d;
  logic [PW-1:0] poll_cnt, poll_d;
  logic          start_c, hs_done_c, hs_timeout_c;

  spi_xfer_hs #(.ACK_MAX(ACK_MAX)) u_hs (
    .clk       (sclk),
    .rst_n     (srst_n),
    .start_c   (start_c),
    .isbusy    (isbusy),
    .trig      (trig),
    .done_c    (hs_done_c),
    .timeout_c (hs_timeout_c)
  );

  // State and output registers
  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      st         <= ST_IDLE;
      busy       <= 1'b0;
      op_done    <= 1'b0;
      op_err     <= 1'b0;
      rdata      <= '0;
      datalength <= '0;
      senddata   <= '0;
      op_q       <= '0;
      addr_q     <= '0;
      nb_q       <= '0;
      wdata_q    <= '0;
      gap_cnt    <= '0;
      poll_cnt   <= '0;
    end else begin
      st         <= st_d;
      busy       <= busy_d;
      op_done    <= op_done_d;
      op_err     <= op_err_d;
      rdata      <= rdata_d;
      datalength <= dl_d;
      senddata   <= sd_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      nb_q       <= nb_d;
      wdata_q    <= wd_d;
      gap_cnt    <= gap_d;
      poll_cnt   <= poll_d;
    end
  end

  // Next-state and payload selection
  always_comb begin
    st_d      = st;
    busy_d    = busy;
    op_done_d = 1'b0;
    op_err_d  = op_err;
    rdata_d   = rdata;
    dl_d      = datalength;
    sd_d      = senddata;
    start_c   = 1'b0;
    op_d      = op_q;
    addr_d    = addr_q;
    nb_d      = nb_q;
    wd_d      = wdata_q;
    gap_d     = gap_cnt;
    poll_d    = poll_cnt;
    case (st)
      ST_IDLE: begin
        if (op_start) begin
          busy_d   = 1'b1;
          op_err_d = 1'b0;
          op_d     = op_code;
          addr_d   = addr;
          nb_d     = nb_clamp(nbytes);
          wd_d     = wdata;
          gap_d    = '0;
          poll_d   = '0;
          case (op_code)
            OPC_READ_ID: begin
              start_c = 1'b1;
              dl_d    = 8'd32;
              sd_d    = 128'({CMD_RDID, 24'h0});
              st_d    = ST_XFER;
            end
            OPC_READ: begin
              start_c = 1'b1;
              dl_d    = xfer_bits(nb_clamp(nbytes));
              sd_d    = cmd_addr(CMD_READ, addr, nb_clamp(nbytes));
              st_d    = ST_XFER;
            end
            OPC_PROGRAM: begin
              if (!nb_valid(nbytes)) begin
                op_done_d = 1'b1;
                op_err_d  = 1'b1;
                st_d      = ST_DONE;
              end else begin
                start_c = 1'b1;
                dl_d    = 8'd8;
                sd_d    = 128'(CMD_WREN);
                st_d    = ST_WREN;
              end
            end
            OPC_ERASE: begin
              start_c = 1'b1;
              dl_d    = 8'd8;
              sd_d    = 128'(CMD_WREN);
              st_d    = ST_WREN;
            end
            default: st_d = ST_IDLE;
          endcase
        end
      end
      ST_WREN: begin
        if (hs_timeout_c) begin
          op_done_d = 1'b1;
          op_err_d  = 1'b1;
          st_d      = ST_DONE;
        end else if (hs_done_c) begin
          start_c = 1'b1;
          st_d    = ST_XFER;
          if (op_q == OPC_PROGRAM) begin
            dl_d = xfer_bits(nb_q);
            // First nb_q bytes of wdata drop into the low byte slots
            sd_d = cmd_addr(CMD_PP, addr_q, nb_q) | (128'(wdata_q) >> (7'd96 - {nb_q, 3'b000}));
          end else begin
            dl_d = 8'd8;
            sd_d = 128'(CMD_CE);
          end
        end
      end
      ST_XFER: begin
        if (hs_timeout_c) begin
          op_done_d = 1'b1;
          op_err_d  = 1'b1;
          st_d      = ST_DONE;
        end else if (hs_done_c) begin
          if (op_q == OPC_READ_ID) begin
            rdata_d   = {recvdata[23:0], 72'h0};
            op_done_d = 1'b1;
            st_d      = ST_DONE;
          end else if (op_q == OPC_READ) begin
            // Data bytes sit in recvdata[8*nb-1:0]; shift them up to rdata[95]
            rdata_d   = 96'(recvdata << (7'd96 - {nb_q, 3'b000}));
            op_done_d = 1'b1;
            st_d      = ST_DONE;
          end else begin
            gap_d = '0;
            st_d  = ST_POLL_GAP;
          end
        end
      end
      ST_POLL_GAP: begin
        if (32'(gap_cnt) + 32'd1 >= POLL_GAP) begin
          start_c = 1'b1;
          dl_d    = 8'd16;
          sd_d    = 128'({CMD_RDSR, 8'h00});
          st_d    = ST_POLL;
        end else begin
          gap_d = gap_cnt + GW'(1);
        end
      end
      ST_POLL: begin
        if (hs_timeout_c) begin
          op_done_d = 1'b1;
          op_err_d  = 1'b1;
          st_d      = ST_DONE;
        end else if (hs_done_c) begin
          poll_d = poll_cnt + PW'(1);
          if (!recvdata[WIP_BIT]) begin
            op_done_d = 1'b1;
            st_d      = ST_DONE;
          end else if (32'(poll_cnt) + 32'd1 >= POLL_MAX) begin
            op_done_d = 1'b1;
            op_err_d  = 1'b1;
            st_d      = ST_DONE;
          end else begin
            gap_d = '0;
            st_d  = ST_POLL_GAP;
          end
        end
      end
      ST_DONE: begin
        busy_d = 1'b0;
        st_d   = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_flash_seq.sv
// Self-checking bench for spi_flash_seq with a behavioural spictl model.
module tb_spi_flash_seq;

  localparam int unsigned ACK_MAX = 15;

  logic         sclk, srst_n, op_start;
  logic [1:0]   op_code;
  logic [23:0]  addr;
  logic [3:0]   nbytes;
  logic [95:0]  wdata;
  logic         busy, op_done, op_err, trig, isbusy;
  logic [95:0]  rdata;
  logic [7:0]   datalength;
  logic [127:0] senddata, recvdata;

  spi_flash_seq #(.POLL_GAP(3), .POLL_MAX(4), .ACK_MAX(ACK_MAX)) dut (
    .sclk(sclk), .srst_n(srst_n), .op_start(op_start), .op_code(op_code),
    .addr(addr), .nbytes(nbytes), .wdata(wdata), .busy(busy), .op_done(op_done),
    .op_err(op_err), .rdata(rdata), .trig(trig), .datalength(datalength),
    .senddata(senddata), .isbusy(isbusy), .recvdata(recvdata)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  // spictl model: isbusy rises 2 cycles after trig for datalength+4 cycles
  logic [127:0] resp;
  logic         stuck_low;
  int           wip_polls, poll_num, mdelay, mbusy;
  logic [7:0]   cur_dl;
  logic [7:0]   log_dl[$];
  logic [127:0] log_sd[$];
  logic [7:0]   exp_dl[$];
  logic [127:0] exp_sd[$];

  always @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      isbusy <= 1'b0; recvdata <= '0; mdelay <= 0; mbusy <= 0; poll_num <= 0; cur_dl <= '0;
    end else begin
      if (op_start && !busy) poll_num <= 0;
      if (trig) begin
        log_dl.push_back(datalength);
        log_sd.push_back(senddata);
        cur_dl <= datalength;
        if (!stuck_low) mdelay <= 1;
      end else if (mdelay == 1) begin
        mdelay <= 0;
        isbusy <= 1'b1;
        mbusy  <= int'(cur_dl) + 4;
      end else if (mbusy > 0) begin
        mbusy <= mbusy - 1;
        if (mbusy == 1) begin
          isbusy <= 1'b0;
          if (cur_dl == 8'd16) begin
            recvdata <= (poll_num < wip_polls) ? 128'h1 : 128'h0;
            poll_num <= poll_num + 1;
          end else begin
            recvdata <= resp;
          end
        end
      end
    end
  end

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  logic [95:0] exp_rd;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_x(input logic [7:0] dl, input logic [127:0] sd);
    exp_dl.push_back(dl);
    exp_sd.push_back(sd);
  endtask

  // Drive one request, wait for op_done, then drain the transfer scoreboard
  task automatic run_op(input string tag, input logic [1:0] code, input logic [23:0] a,
                        input logic [3:0] nb, input logic [95:0] wd, input logic exp_err,
                        output int ncyc);
    logic exp_trig;
    logic seen;
    int   n;
    exp_trig = (exp_dl.size() > 0);
    @(negedge sclk);
    op_start = 1'b1; op_code = code; addr = a; nbytes = nb; wdata = wd;
    @(negedge sclk);
    op_start = 1'b0;
    check({tag, "_busy_rise"}, 128'(busy), 128'(1'b1));
    check({tag, "_trig_first"}, 128'(trig), 128'(exp_trig));
    ncyc = 0;
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (op_done) begin seen = 1'b1; break; end
      @(negedge sclk);
      ncyc++;
    end
    check({tag, "_done_seen"}, 128'(seen), 128'(1'b1));
    check({tag, "_err"}, 128'(op_err), 128'(exp_err));
    check({tag, "_rdata"}, 128'(rdata), 128'(exp_rd));
    @(negedge sclk);
    check({tag, "_busy_fall"}, 128'({busy, op_done}), 128'(2'b00));
    n = exp_dl.size();
    check({tag, "_nxfer"}, 128'(log_dl.size()), 128'(n));
    while (exp_dl.size() > 0 && log_dl.size() > 0) begin
      check({tag, "_dl"}, 128'(log_dl.pop_front()), 128'(exp_dl.pop_front()));
      check({tag, "_sd"}, log_sd.pop_front(), exp_sd.pop_front());
    end
    exp_dl.delete(); exp_sd.delete(); log_dl.delete(); log_sd.delete();
  endtask

  initial begin
    int   ncyc;
    logic seen;
    srst_n = 1'b0; op_start = 1'b0; op_code = '0; addr = '0; nbytes = '0; wdata = '0;
    stuck_low = 1'b0; wip_polls = 0; resp = '0; exp_rd = '0;
    repeat (3) @(negedge sclk);
    check("rst_busy", 128'(busy), 128'(1'b0));
    check("rst_done_err", 128'({op_done, op_err}), 128'(2'b00));
    check("rst_rdata", 128'(rdata), 128'(0));
    check("rst_trig", 128'(trig), 128'(1'b0));
    check("rst_dl", 128'(datalength), 128'(0));
    check("rst_sd", senddata, 128'(0));
    srst_n = 1'b1;
    @(negedge sclk);

    // READ_ID
    resp = 128'h00EF4017;
    push_x(8'd32, 128'h9F000000);
    exp_rd = {24'hEF4017, 72'h0};
    run_op("rdid", 2'd0, 24'h0, 4'd0, 96'h0, 1'b0, ncyc);

    // READ two bytes; high recvdata bits are command-phase garbage
    resp = 128'hDEADBEEF_A55A;
    push_x(8'd48, 128'h030012340000);
    exp_rd = {16'hA55A, 80'h0};
    run_op("read2", 2'd1, 24'h001234, 4'd2, 96'h0, 1'b0, ncyc);

    // READ with nbytes=0 clamps to 12
    resp = {32'hCAFEF00D, 96'h0102030405060708090A0B0C};
    push_x(8'd128, {8'h03, 24'hABCDEF, 96'h0});
    exp_rd = 96'h0102030405060708090A0B0C;
    run_op("read_clamp", 2'd1, 24'hABCDEF, 4'd0, 96'h0, 1'b0, ncyc);

    // PROGRAM one byte, WIP=1 for three polls; rdata holds
    wip_polls = 3;
    push_x(8'd8, 128'h06);
    push_x(8'd40, 128'h020001003C);
    for (int i = 0; i < 4; i++) push_x(8'd16, 128'h0500);
    run_op("prog", 2'd2, 24'h000100, 4'd1, {8'h3C, 88'h0}, 1'b0, ncyc);

    // PROGRAM with invalid nbytes: error, no SPI traffic
    run_op("prog_bad", 2'd2, 24'h000100, 4'd13, 96'h0, 1'b1, ncyc);

    // ERASE with spictl never acknowledging
    stuck_low = 1'b1;
    push_x(8'd8, 128'h06);
    run_op("erase_noack", 2'd3, 24'h0, 4'd0, 96'h0, 1'b1, ncyc);
    check("erase_noack_latency", 128'(ncyc <= int'(ACK_MAX) + 3), 128'(1'b1));
    stuck_low = 1'b0;

    // ERASE with WIP stuck: exactly POLL_MAX polls then error
    wip_polls = 1000;
    push_x(8'd8, 128'h06);
    push_x(8'd8, 128'hC7);
    for (int i = 0; i < 4; i++) push_x(8'd16, 128'h0500);
    run_op("erase_wip", 2'd3, 24'h0, 4'd0, 96'h0, 1'b1, ncyc);

    // Reset in the middle of the poll loop
    @(negedge sclk);
    op_start = 1'b1; op_code = 2'd3;
    @(negedge sclk);
    op_start = 1'b0;
    for (int i = 0; i < 3000 && log_dl.size() < 3; i++) @(negedge sclk);
    check("abort_reached_poll", 128'(log_dl.size() >= 3), 128'(1'b1));
    srst_n = 1'b0;
    #1;
    check("abort_trig_busy", 128'({trig, busy}), 128'(2'b00));
    @(negedge sclk);
    srst_n = 1'b1;
    log_dl.delete(); log_sd.delete();
    seen = 1'b0;
    repeat (60) begin
      @(negedge sclk);
      if (op_done) seen = 1'b1;
    end
    check("abort_no_done", 128'(seen), 128'(1'b0));
    check("abort_idle_busy", 128'(busy), 128'(1'b0));
    exp_rd = '0;
    check("abort_rdata_cleared", 128'(rdata), 128'(exp_rd));
    check("abort_no_xfer", 128'(log_dl.size()), 128'(0));

    // READ_ID after abort
    resp = 128'h00C22017;
    push_x(8'd32, 128'h9F000000);
    exp_rd = {24'hC22017, 72'h0};
    run_op("rdid2", 2'd0, 24'h0, 4'd0, 96'h0, 1'b0, ncyc);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
